// File: rtl/wb_keyboard.sv
// wb_keyboard: PS/2 keyboard receiver feeding a scancode FIFO, read over a
// single-cycle-ACK Wishbone slave with DATA (ADDR[2]=0) and STATUS (ADDR[2]=1).
module wb_keyboard #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // Synchronizer and edge-detect state
  logic clk_meta, clk_sync, clk_prev, data_meta, data_sync, fall;

  // Receiver state
  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_bit_n;
  logic [WW-1:0] wd, wd_n;
  logic          frame_ok, frame_bad;
  logic          push_pend, err_pend;
  logic [7:0]    push_code;

  // FIFO and bus state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          overflow, overflow_n, par_err, par_err_n, served;
  logic          ack_n, pop, push_ok, nonempty, full, wr_status;
  logic [4:0]    count_w;
  logic [31:0]   dat_n;
  logic          unused_bits;

  assign nonempty = (count != '0);
  assign full     = (count == FULL_CNT);
  assign count_w  = 5'(count);
  assign fall     = clk_prev & ~clk_sync;
  assign unused_bits = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:7], DAT_I[4:0], count_w[4]};

  // Bring the asynchronous PS/2 lines into the clk domain; idle level is 1.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of the others.
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Receiver next-state logic: advance only on PS/2 falling edges, or bail out on watchdog expiry.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    wd_n      = (state == IDLE || fall) ? '0 : wd + 1'b1;
    if (fall) begin
      case (state)
        IDLE: if (!data_sync) begin
          state_n   = DATA;
          bit_cnt_n = 3'd0;
        end
        DATA: begin
          shreg_n   = {data_sync, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_bit_n = data_sync;
          state_n   = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (data_sync && (^shreg ^ par_bit)) frame_ok  = 1'b1;
          else                                 frame_bad = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && wd == WD_LIMIT) begin
      state_n = IDLE;
      wd_n    = '0;
    end
  end

  // Receiver registers; a finished frame is handed to the FIFO one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      par_bit   <= 1'b0;
      wd        <= '0;
      push_pend <= 1'b0;
      err_pend  <= 1'b0;
      push_code <= 8'd0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par_bit   <= par_bit_n;
      wd        <= wd_n;
      push_pend <= frame_ok;
      err_pend  <= frame_bad;
      push_code <= shreg;
    end
  end

  // Bus decode, FIFO occupancy and sticky-flag next values (flag set beats clear).
  always_comb begin
    ack_n     = STB & ~ACK & ~served;
    pop       = ack_n & ~WE & ~ADDR[2] & nonempty;
    push_ok   = push_pend & ~full;
    wr_status = ack_n & WE & ADDR[2];
    count_n   = count;
    case ({push_ok, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
    overflow_n = overflow;
    if (wr_status && DAT_I[5]) overflow_n = 1'b0;
    if (push_pend && full)     overflow_n = 1'b1;
    par_err_n = par_err;
    if (wr_status && DAT_I[6]) par_err_n = 1'b0;
    if (err_pend)              par_err_n = 1'b1;
    dat_n = 32'd0;
    if (ack_n && !WE) begin
      if (ADDR[2])       dat_n = {25'd0, par_err, overflow, full, count_w[3:0]};
      else if (nonempty) dat_n = {23'd0, 1'b1, mem[rd_ptr]};
    end
  end

  // FIFO storage; pointer/count bookkeeping lives in the block below.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the cleared count
    // already marks every entry as invalid.
    if (push_ok) mem[wr_ptr] <= push_code;
  end

  // Pointers, flags, interrupt and the one-shot Wishbone handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      par_err  <= 1'b0;
      ACK      <= 1'b0;
      DAT_O    <= 32'd0;
      irq      <= 1'b0;
      served   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count    <= count_n;
      overflow <= overflow_n;
      par_err  <= par_err_n;
      ACK      <= ack_n;
      DAT_O    <= dat_n;
      irq      <= (count_n != '0);
      served   <= STB & (served | ack_n);
    end
  end

endmodule
